// File: rtl/gf2_polydiv_193.sv
// gf2_polydiv_193: sequential GF(2) long divider, one quotient bit per clock.
// y = q*b + r with deg(r) < deg(b); err flags a zero divisor.
module gf2_polydiv_193 #(
    parameter int N = 193
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2*N-2:0]   y,
    input  logic [N-1:0]     b,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [2*N-2:0]   q,
    output logic [N-2:0]     r
);
    localparam int CW = $clog2(2*N-1);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
    state_t state, state_nx;
    logic [2*N-2:0] y_q;
    logic [N-1:0]   b_q, p, s;
    logic [7:0]     d, deg_b;
    logic [CW-1:0]  cnt;
    logic           acc;
    always_comb begin
        deg_b = '0;
        for (int i = 0; i < N; i++)
            if (b[i]) deg_b = 8'(i);
    end
    assign acc  = (state == IDLE) && start;
    assign busy = (state != IDLE);
    // dividend is consumed MSB first by shifting the latched copy left
    assign s    = {p[N-2:0], y_q[2*N-2]};
    always_comb begin
        state_nx = state;
        if (acc)
            state_nx = (b == '0) ? FIN : RUN;
        else if (state == RUN && cnt == '0)
            state_nx = FIN;
        else if (state == FIN)
            state_nx = IDLE;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q  <= '0;
            b_q  <= '0;
            d    <= '0;
            p    <= '0;
            cnt  <= '0;
            q    <= '0;
            r    <= '0;
            err  <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= (state == FIN);
            if (acc) begin
                y_q <= y;
                b_q <= b;
                d   <= deg_b;
                p   <= '0;
                q   <= '0;
                r   <= '0;
                cnt <= CW'(2*N-2);
                err <= (b == '0);
            end else if (state == RUN) begin
                p   <= s[d] ? s ^ b_q : s;
                q   <= {q[2*N-3:0], s[d]};
                y_q <= y_q << 1;
                cnt <= (cnt == '0) ? cnt : cnt - 1'b1;
            end else if (state == FIN) begin
                r <= p[N-2:0];
            end
        end
    end
endmodule

// File: tb/tb_gf2_polydiv_193.sv
// tb_gf2_polydiv_193: randomized bench for the GF(2) divider against a
// textbook long-division / carry-less multiply model.
module tb_gf2_polydiv_193;
    logic         clk = 0, rst_n = 1, start = 0;
    logic [384:0] y = '0;
    logic [192:0] b = '0;
    logic         busy, done, err;
    logic [384:0] q;
    logic [191:0] r;
    int tests = 0, fails = 0;

    gf2_polydiv_193 dut (.clk(clk), .rst_n(rst_n), .start(start), .y(y), .b(b),
                         .busy(busy), .done(done), .err(err), .q(q), .r(r));

    always #5 clk = ~clk;

    function automatic logic [384:0] clmul(input logic [384:0] a, input logic [192:0] m);
        logic [384:0] acc = '0;
        for (int i = 0; i < 193; i++)
            if (m[i]) acc ^= a << i;
        return acc;
    endfunction

    function automatic int deg(input logic [384:0] v);
        int dg = -1;
        for (int i = 0; i < 385; i++)
            if (v[i]) dg = i;
        return dg;
    endfunction

    function automatic void ref_div(input logic [384:0] yv, input logic [192:0] bv,
                                    output logic [384:0] qv, output logic [191:0] rv);
        logic [384:0] rem = yv;
        logic [384:0] bw = {192'b0, bv};
        int db = deg(bw);
        qv = '0;
        for (int i = 384; i >= db; i--)
            if (rem[i]) begin
                rem ^= bw << (i - db);
                qv[i - db] = 1'b1;
            end
        rv = rem[191:0];
    endfunction

    function automatic logic [384:0] rnd385();
        logic [384:0] v = '0;
        for (int k = 0; k < 13; k++) v = (v << 32) | 385'($urandom);
        return v;
    endfunction

    task automatic do_div(input logic [384:0] yv, input logic [192:0] bv,
                          output int lat, output int bcnt, output logic err0);
        @(negedge clk);
        y = yv; b = bv; start = 1;
        @(posedge clk); #1;
        start = 0; lat = 0; bcnt = busy ? 1 : 0; err0 = err;
        while (!done && lat < 500) begin
            @(posedge clk); #1;
            lat++;
            if (busy) bcnt++;
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 0;
        #1;
        tests++;
        if ({busy, done, err, q, r} !== '0) begin
            fails++;
            $display("FAIL reset_outputs busy=%b done=%b err=%b q=%h r=%h required all 0", busy, done, err, q, r);
        end
        @(negedge clk); rst_n = 1;
    endtask

    task automatic test_simple();
        int lat, bc; logic e0;
        do_div(385'h7, 193'h3, lat, bc, e0);
        tests++;
        if (lat !== 386) begin fails++; $display("FAIL simple_latency got %0d required 386", lat); end
        tests++;
        if (bc !== 386) begin fails++; $display("FAIL simple_busy_cycles got %0d required 386", bc); end
        tests++;
        if (q !== 385'h2 || r !== 192'h1 || err !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL simple_result q=%h r=%h err=%b busy=%b required q=2 r=1 err=0 busy=0", q, r, err, busy);
        end
        @(posedge clk); #1;
        tests++;
        if (done !== 1'b0) begin fails++; $display("FAIL simple_done_pulse done=%b required 0", done); end
    endtask

    task automatic test_boundary();
        int lat, bc; logic e0;
        logic [384:0] ya = '0, eq;
        logic [192:0] bb;
        ya[384] = 1'b1;
        bb = '0; bb[192] = 1'b1;
        eq = '0; eq[192] = 1'b1;
        do_div(ya, bb, lat, bc, e0);
        tests++;
        if (q !== eq || r !== '0 || lat !== 386) begin
            fails++; $display("FAIL bnd_top_deg q=%h r=%h lat=%0d required q=%h r=0 lat=386", q, r, lat, eq);
        end
        do_div(ya, 193'h1, lat, bc, e0);
        tests++;
        if (q !== ya || r !== '0) begin
            fails++; $display("FAIL bnd_div_by_one q=%h r=%h required q=%h r=0", q, r, ya);
        end
        bb[0] = 1'b1;
        do_div('1, bb, lat, bc, e0);
        tests++;
        if ((clmul(q, bb) ^ {193'b0, r}) !== {385{1'b1}} || deg({193'b0, r}) >= 192) begin
            fails++; $display("FAIL bnd_all_ones q=%h r=%h required q*b^r=all ones and deg(r)<192", q, r);
        end
    endtask

    task automatic test_roundtrip();
        int lat, bc; logic e0;
        logic [192:0] a, bv;
        logic [384:0] yv, eq;
        logic [191:0] er;
        for (int n = 0; n < 60; n++) begin
            a  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom[0]};
            bv = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom[0]};
            bv = bv >> $urandom_range(0, 192);
            if (bv == '0) bv = 193'h1;
            yv = clmul({192'b0, a}, bv);
            do_div(yv, bv, lat, bc, e0);
            tests++;
            if (q !== {192'b0, a} || r !== '0 || err !== 1'b0 || lat !== 386) begin
                fails++; $display("FAIL roundtrip[%0d] q=%h r=%h err=%b lat=%0d required q=%h r=0 err=0 lat=386", n, q, r, err, lat, a);
            end
        end
        for (int n = 0; n < 30; n++) begin
            yv = rnd385();
            bv = rnd385()[192:0] >> $urandom_range(0, 192);
            if (bv == '0) bv = 193'h2;
            ref_div(yv, bv, eq, er);
            do_div(yv, bv, lat, bc, e0);
            tests++;
            if (q !== eq || r !== er || (clmul(q, bv) ^ {193'b0, r}) !== yv || deg({193'b0, r}) >= deg({192'b0, bv})) begin
                fails++; $display("FAIL random_div[%0d] q=%h r=%h required q=%h r=%h", n, q, r, eq, er);
            end
        end
    endtask

    task automatic test_div0();
        int lat, bc; logic e0;
        logic [384:0] eq;
        logic [191:0] er;
        do_div(rnd385(), '0, lat, bc, e0);
        tests++;
        if (lat !== 1 || done !== 1'b1 || err !== 1'b1 || q !== '0 || r !== '0 || busy !== 1'b0) begin
            fails++; $display("FAIL div0 lat=%0d done=%b err=%b q=%h r=%h busy=%b required lat=1 done=1 err=1 q=0 r=0 busy=0", lat, done, err, q, r, busy);
        end
        ref_div(385'h1234567, 193'h1b, eq, er);
        do_div(385'h1234567, 193'h1b, lat, bc, e0);
        tests++;
        if (e0 !== 1'b0 || err !== 1'b0 || q !== eq || r !== er) begin
            fails++; $display("FAIL div0_clear err_at_start=%b err=%b q=%h r=%h required err 0 q=%h r=%h", e0, err, q, r, eq, er);
        end
    endtask

    task automatic test_protocol();
        int lat, bc, dn; logic e0;
        logic [384:0] y1, eq;
        logic [192:0] b1;
        logic [191:0] er;
        y1 = rnd385();
        b1 = rnd385()[192:0] | 193'h1;
        ref_div(y1, b1, eq, er);
        @(negedge clk); y = y1; b = b1; start = 1;
        @(posedge clk); #1; start = 0; lat = 0;
        repeat (99) begin @(posedge clk); lat++; end
        @(negedge clk); y = rnd385(); b = 193'h5; start = 1;
        @(posedge clk); #1; start = 0; lat++;
        while (!done && lat < 500) begin @(posedge clk); #1; lat++; end
        tests++;
        if (lat !== 386 || q !== eq || r !== er) begin
            fails++; $display("FAIL ignored_start lat=%0d q=%h r=%h required lat=386 q=%h r=%h", lat, q, r, eq, er);
        end
        @(negedge clk); y = y1; b = b1; start = 1;
        @(posedge clk); #1; start = 0;
        repeat (200) @(posedge clk);
        #2 rst_n = 0;
        #1;
        tests++;
        if ({busy, done, err, q, r} !== '0) begin
            fails++; $display("FAIL midrun_reset busy=%b done=%b err=%b q=%h r=%h required all 0", busy, done, err, q, r);
        end
        repeat (3) @(negedge clk);
        rst_n = 1;
        dn = 0;
        repeat (400) begin @(posedge clk); #1; if (done) dn++; end
        tests++;
        if (dn !== 0) begin fails++; $display("FAIL reset_no_done done_pulses=%0d required 0", dn); end
        do_div(y1, b1, lat, bc, e0);
        tests++;
        if (lat !== 386 || q !== eq || r !== er) begin
            fails++; $display("FAIL after_reset lat=%0d q=%h r=%h required lat=386 q=%h r=%h", lat, q, r, eq, er);
        end
    endtask

    initial begin
        test_reset();
        test_simple();
        test_boundary();
        test_div0();
        test_protocol();
        test_roundtrip();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
